// File: rtl/instr_fetch_unit_if.sv
// Decoder-facing handshake of the fetch unit: the instruction stream flows
// out, redirect requests flow back in.
interface instr_fetch_if;
   logic        redirect;
   logic [63:0] redirect_offset;
   logic        inst_ready;
   logic        inst_valid;
   logic [31:0] instruction;
   logic [63:0] inst_pc;
   logic        fault;
   logic [63:0] fault_pc;

   modport master (
      input  redirect, redirect_offset, inst_ready,
      output inst_valid, instruction, inst_pc, fault, fault_pc
   );

   modport slave (
      output redirect, redirect_offset, inst_ready,
      input  inst_valid, instruction, inst_pc, fault, fault_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, synchronous-read instruction memory and a 2-deep output queue.
// Optional performance counters are enabled with `define INSTR_FETCH_PERF_EN.
module instr_fetch_unit #(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter logic [63:0] RESET_PC   = 64'd0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                   imem_wdata,
`ifdef INSTR_FETCH_PERF_EN
   output logic [31:0]                   perf_fetched,
   output logic [31:0]                   perf_flushed,
   output logic [31:0]                   perf_stall,
`endif
   instr_fetch_if.master                 bus
);
   localparam int unsigned AW       = $clog2(IMEM_DEPTH);
   localparam logic [63:0] PC_LIMIT = 64'(IMEM_DEPTH) << 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

   logic [31:0] mem_q [IMEM_DEPTH];
   state_e      state_q;
   logic [63:0] pc_f_q;
   logic        fault_q;
   logic [63:0] fault_pc_q;
   logic        inflight_q;
   logic [31:0] rd_instr_q;
   logic [63:0] rd_pc_q;
   logic [1:0]  count_q, count_d;
   logic [31:0] q_instr_q [2];
   logic [63:0] q_pc_q [2];

   logic        valid, pop, redir, from_q;
   logic        want_issue, oor, issue, oor_fault, mis_fault;
   logic        push, shift;
   logic [1:0]  occ, occ_after, cnt_base;
   logic [63:0] target;

   // The read returning this cycle is bypassed to the head when the queue is empty.
   assign from_q    = (count_q != 2'd0);
   assign valid     = from_q | inflight_q;
   assign pop       = valid & bus.inst_ready;
   assign redir     = valid & bus.redirect;
   assign target    = bus.inst_pc + bus.redirect_offset;

   assign occ        = count_q + {1'b0, inflight_q};
   assign occ_after  = occ - {1'b0, pop};
   assign want_issue = (state_q == RUN) & ~redir & ~occ_after[1];
   assign oor        = (pc_f_q >= PC_LIMIT);
   assign issue      = want_issue & ~oor;
   assign oor_fault  = want_issue & oor;
   assign mis_fault  = redir & (state_q == RUN) & (target[1:0] != 2'b00);

   assign bus.inst_valid  = valid;
   assign bus.instruction = from_q ? q_instr_q[0] : rd_instr_q;
   assign bus.inst_pc     = from_q ? q_pc_q[0] : rd_pc_q;
   assign bus.fault       = fault_q;
   assign bus.fault_pc    = fault_pc_q;

   always_comb begin
      push     = inflight_q & ~redir & ~(pop & ~from_q);
      shift    = pop & from_q & ~redir;
      cnt_base = count_q - {1'b0, shift};
      count_d  = redir ? 2'd0 : cnt_base + {1'b0, push};
   end

   always_ff @(posedge clk) begin
      if (imem_we) mem_q[imem_waddr] <= imem_wdata;
   end

   // Queue payload is never observed while count_q is zero, so it carries no reset.
   always_ff @(posedge clk) begin
      if (shift) begin
         q_instr_q[0] <= q_instr_q[1];
         q_pc_q[0]    <= q_pc_q[1];
      end
      if (push) begin
         q_instr_q[cnt_base[0]] <= rd_instr_q;
         q_pc_q[cnt_base[0]]    <= rd_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         rd_instr_q <= NOP;
         rd_pc_q    <= 64'd0;
         count_q    <= 2'd0;
      end else begin
         inflight_q <= issue;
         count_q    <= count_d;
         if (issue) begin
            rd_instr_q <= mem_q[pc_f_q[AW+1:2]];
            rd_pc_q    <= pc_f_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_f_q     <= RESET_PC;
         fault_q    <= 1'b0;
         fault_pc_q <= 64'd0;
      end else begin
         if (redir)      pc_f_q <= target;
         else if (issue) pc_f_q <= pc_f_q + 64'd4;
         case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
               if (mis_fault | oor_fault) begin
                  state_q    <= HALT;
                  fault_q    <= 1'b1;
                  fault_pc_q <= mis_fault ? target : pc_f_q;
               end
            end
            HALT:    state_q <= HALT;
            default: state_q <= HALT;
         endcase
      end
   end

`ifdef INSTR_FETCH_PERF_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   logic [31:0] perf_fetched_q, perf_flushed_q, perf_stall_q;
   logic [31:0] flush_inc;

   // The presented entry counts as consumed, so only the entries behind it are flushed.
   assign flush_inc = redir ? ({30'd0, occ} - 32'd1) : 32'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= 32'd0;
         perf_flushed_q <= 32'd0;
         perf_stall_q   <= 32'd0;
      end else begin
         perf_fetched_q <= sat_add(perf_fetched_q, {31'd0, pop});
         perf_flushed_q <= sat_add(perf_flushed_q, flush_inc);
         perf_stall_q   <= sat_add(perf_stall_q, {31'd0, valid & ~bus.inst_ready});
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
   assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch/stall/redirect/fault steps, then
// randomized ready/redirect traffic checked against a program-order stream model.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n, rst4_n;
   logic        imem_we, imem_we4;
   logic [7:0]  imem_waddr;
   logic [1:0]  imem_waddr4;
   logic [31:0] imem_wdata, imem_wdata4;

   instr_fetch_if bus ();
   instr_fetch_if bus4 ();

`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] pf_a, pl_a, ps_a, pf_b, pl_b, ps_b;
`endif

   instr_fetch_unit #(.IMEM_DEPTH(256)) dut (
      .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata),
`ifdef INSTR_FETCH_PERF_EN
      .perf_fetched(pf_a), .perf_flushed(pl_a), .perf_stall(ps_a),
`endif
      .bus(bus)
   );

   instr_fetch_unit #(.IMEM_DEPTH(4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .imem_we(imem_we4), .imem_waddr(imem_waddr4),
      .imem_wdata(imem_wdata4),
`ifdef INSTR_FETCH_PERF_EN
      .perf_fetched(pf_b), .perf_flushed(pl_b), .perf_stall(ps_b),
`endif
      .bus(bus4)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   logic [31:0] mem_m [256];
   logic [31:0] init_w [4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic present(input string tag, input logic [63:0] pc);
      chk({tag, "_valid"}, {63'd0, bus.inst_valid}, 64'd1);
      chk({tag, "_pc"}, bus.inst_pc, pc);
      chk({tag, "_instr"}, {32'd0, bus.instruction}, {32'd0, mem_m[pc[9:2]]});
   endtask

   task automatic redirect_to(input logic [63:0] off);
      bus.redirect        = 1'b1;
      bus.redirect_offset = off;
      step();
      bus.redirect        = 1'b0;
      bus.redirect_offset = 64'd0;
   endtask

   initial begin
      logic [63:0] exp_pc, hold_pc, pc, off;
      logic [31:0] hold_ins;
      logic        chk_hold, do_redir, v;
      int          redir_age;
      logic [63:0] got_pc [$];
      logic [31:0] got_ins [$];
      bit          faulted;

      init_w = '{32'h13, 32'h93, 32'h113, 32'h193};
      rst_n = 1'b0; rst4_n = 1'b0;
      imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      imem_we4 = 1'b0; imem_waddr4 = '0; imem_wdata4 = '0;
      bus.redirect = 1'b0; bus.redirect_offset = 64'd0; bus.inst_ready = 1'b1;
      bus4.redirect = 1'b0; bus4.redirect_offset = 64'd0; bus4.inst_ready = 1'b1;
      @(negedge clk);

      chk("rst_valid", {63'd0, bus.inst_valid}, 64'd0);
      chk("rst_instr", {32'd0, bus.instruction}, 64'h13);
      chk("rst_pc", bus.inst_pc, 64'd0);
      chk("rst_fault", {63'd0, bus.fault}, 64'd0);
      chk("rst_fault_pc", bus.fault_pc, 64'd0);

      // Program load while both units are held in reset
      for (int i = 0; i < 256; i++) begin
         imem_we    = 1'b1;
         imem_waddr = 8'(i);
         imem_wdata = (i < 4) ? init_w[i] : $urandom;
         mem_m[i]   = imem_wdata;
         imem_we4    = (i < 4);
         imem_waddr4 = 2'(i);
         imem_wdata4 = imem_wdata;
         step();
      end
      imem_we = 1'b0; imem_we4 = 1'b0;

      rst_n = 1'b1;
      step();
      chk("boot_valid", {63'd0, bus.inst_valid}, 64'd0);
      step();
      present("first", 64'h0);
      step();
      present("second", 64'h4);

      bus.inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         present("stall", 64'h4);
      end
      bus.inst_ready = 1'b1;
      step();
      present("resume", 64'h8);

      redirect_to(64'h10);
      chk("redir_gap", {63'd0, bus.inst_valid}, 64'd0);
      step();
      present("redir_fwd", 64'h18);

      redirect_to(-64'sd12);
      step();
      present("redir_c", 64'hC);
      redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
      step();
      present("redir_back", 64'h4);
      redirect_to(-64'sd4);
      step();
      present("redir_zero", 64'h0);

      redirect_to(64'd6);
      chk("mis_fault", {63'd0, bus.fault}, 64'd1);
      chk("mis_fault_pc", bus.fault_pc, 64'd6);
      chk("mis_valid", {63'd0, bus.inst_valid}, 64'd0);
      for (int i = 0; i < 3; i++) step();
      chk("halt_fault", {63'd0, bus.fault}, 64'd1);
      chk("halt_valid", {63'd0, bus.inst_valid}, 64'd0);
      chk("halt_fault_pc", bus.fault_pc, 64'd6);

      rst_n = 1'b0;
      #1;
      chk("arst_fault", {63'd0, bus.fault}, 64'd0);
      chk("arst_valid", {63'd0, bus.inst_valid}, 64'd0);
      chk("arst_pc", bus.inst_pc, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against a program-order model of the delivered stream
      exp_pc = 64'd0; chk_hold = 1'b0; redir_age = 0;
      hold_pc = 64'd0; hold_ins = 32'd0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         step();
         v  = bus.inst_valid;
         pc = bus.inst_pc;
         if (chk_hold) begin
            chk("r_hold_valid", {63'd0, v}, 64'd1);
            chk("r_hold_pc", pc, hold_pc);
            chk("r_hold_instr", {32'd0, bus.instruction}, {32'd0, hold_ins});
         end
         if (redir_age == 1) chk("r_redir_gap", {63'd0, v}, 64'd0);
         if (redir_age == 2) chk("r_redir_lat", {63'd0, v}, 64'd1);
         if (v) begin
            chk("r_pc", pc, exp_pc);
            chk("r_instr", {32'd0, bus.instruction}, {32'd0, mem_m[pc[9:2]]});
         end

         bus.inst_ready = ($urandom_range(0, 3) != 0);
         do_redir = v ? ((pc >= 64'h380) || ($urandom_range(0, 7) == 0))
                      : ($urandom_range(0, 5) == 0);
         off = {$urandom, $urandom};
         if (v && do_redir) off = 64'($urandom_range(0, 191)) * 64'd4 - pc;
         bus.redirect        = do_redir;
         bus.redirect_offset = do_redir ? off : 64'd0;

         chk_hold = v & ~bus.inst_ready & ~do_redir;
         hold_pc  = pc;
         hold_ins = bus.instruction;
         if (v && do_redir) begin
            exp_pc    = pc + off;
            redir_age = 1;
         end else begin
            if (v && bus.inst_ready) exp_pc = exp_pc + 64'd4;
            redir_age = (redir_age != 0 && redir_age < 3) ? redir_age + 1 : 0;
         end
      end
      bus.redirect = 1'b0;
      bus.redirect_offset = 64'd0;
      step();
      chk("r_nofault", {63'd0, bus.fault}, 64'd0);

      // Four-word memory: fetch runs off the end
      rst4_n = 1'b1;
      faulted = 1'b0;
      for (int i = 0; i < 20 && !faulted; i++) begin
         step();
         if (bus4.inst_valid) begin
            got_pc.push_back(bus4.inst_pc);
            got_ins.push_back(bus4.instruction);
         end
         if (bus4.fault) faulted = 1'b1;
      end
      chk("oor_reached", {63'd0, faulted}, 64'd1);
      chk("oor_count", 64'(got_pc.size()), 64'd4);
      for (int i = 0; i < got_pc.size() && i < 4; i++) begin
         chk("oor_pc", got_pc[i], 64'(i * 4));
         chk("oor_instr", {32'd0, got_ins[i]}, {32'd0, init_w[i]});
      end
      chk("oor_fault_pc", bus4.fault_pc, 64'h10);
      chk("oor_valid", {63'd0, bus4.inst_valid}, 64'd0);

      rst4_n = 1'b0;
      #1;
      chk("oor_arst_fault", {63'd0, bus4.fault}, 64'd0);
      chk("oor_arst_valid", {63'd0, bus4.inst_valid}, 64'd0);
      @(negedge clk);
      rst4_n = 1'b1;
      step();
      step();
      chk("restart_valid", {63'd0, bus4.inst_valid}, 64'd1);
      chk("restart_pc", bus4.inst_pc, 64'd0);
      chk("restart_instr", {32'd0, bus4.instruction}, 64'h13);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
